// File: rtl/wf_rr_arbiter.sv
// Round-robin arbiter over 40 wavefront slots with a registered, ack-held grant.
// The search starts one slot past the last grant and wraps circularly through 0..39.
module wf_rr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] req,
    input  logic        grant_ack,
    output logic        grant_valid,
    output logic [5:0]  grant_id,
    output logic [39:0] grant_onehot
);

    logic        grant_valid_q, grant_valid_d;
    logic [5:0]  grant_id_q, grant_id_d;
    logic [39:0] grant_onehot_q, grant_onehot_d;
    logic [5:0]  last_grant_q, last_grant_d;

    logic [5:0]  start;
    logic [39:0] rotated;
    logic [5:0]  k;
    logic [6:0]  sum;
    logic [6:0]  idx;
    logic [5:0]  winner;
    logic        update;

    always_comb begin
        start = (last_grant_q == 6'd39) ? 6'd0 : last_grant_q + 6'd1;

        // Rotated bit k is req[(start+k) mod 40], so the lowest set bit is the next requester.
        rotated = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            idx = {1'b0, start} + 7'(i);
            if (idx >= 7'd40) begin
                idx = idx - 7'd40;
            end
            rotated[i] = req[idx[5:0]];
        end

        k = '0;
        for (int unsigned i = 40; i > 0; i--) begin
            if (rotated[i-1]) begin
                k = 6'(i - 1);
            end
        end

        sum    = {1'b0, start} + {1'b0, k};
        winner = (sum >= 7'd40) ? 6'(sum - 7'd40) : sum[5:0];
        update = !grant_valid_q || grant_ack;

        grant_valid_d  = grant_valid_q;
        grant_id_d     = grant_id_q;
        grant_onehot_d = grant_onehot_q;
        last_grant_d   = last_grant_q;
        if (update) begin
            if (|req) begin
                grant_valid_d  = 1'b1;
                grant_id_d     = winner;
                grant_onehot_d = 40'd1 << winner;
                last_grant_d   = winner;
            end else begin
                grant_valid_d  = 1'b0;
                grant_onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid_q  <= 1'b0;
            grant_id_q     <= '0;
            grant_onehot_q <= '0;
            last_grant_q   <= 6'd39;
        end else begin
            grant_valid_q  <= grant_valid_d;
            grant_id_q     <= grant_id_d;
            grant_onehot_q <= grant_onehot_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_id     = grant_id_q;
    assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_wf_rr_arbiter.sv
// Self-checking bench for wf_rr_arbiter: directed vector table, full-rotation
// sweep and randomized traffic against a circular-search reference model.
module tb_wf_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [39:0] req;
    logic        grant_ack;
    logic        grant_valid;
    logic [5:0]  grant_id;
    logic [39:0] grant_onehot;

    int unsigned n_pass;
    int unsigned n_total;

    // Reference model state
    logic        m_valid;
    logic [5:0]  m_id;
    int unsigned m_last;

    wf_rr_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_ack    (grant_ack),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .grant_onehot (grant_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [39:0] req;
        logic        ack;
        logic        ev;
        logic [5:0]  eid;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next grant found by walking slots last+1, last+2, ... modulo 40.
    task automatic model_edge(input logic r, input logic [39:0] rq, input logic a);
        if (r) begin
            m_valid = 1'b0;
            m_id    = 6'd0;
            m_last  = 39;
        end else if (!m_valid || a) begin
            if (rq == 40'd0) begin
                m_valid = 1'b0;
            end else begin
                for (int unsigned i = 1; i <= 40; i++) begin
                    int unsigned s;
                    s = (m_last + i) % 40;
                    if (rq[s]) begin
                        m_valid = 1'b1;
                        m_id    = 6'(s);
                        m_last  = s;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [39:0] rq, input logic a);
        rst       = r;
        req       = rq;
        grant_ack = a;
        @(posedge clk);
        model_edge(r, rq, a);
        #1;
    endtask

    function automatic logic [39:0] onehot_of(input logic v, input logic [5:0] id);
        logic [39:0] one;
        one = 40'd1;
        return v ? (one << id) : 40'd0;
    endfunction

    initial begin
        logic [39:0] all_ones;
        logic [39:0] r;
        int unsigned counts[40];
        logic        ok;

        n_pass    = 0;
        n_total   = 0;
        m_valid   = 1'b0;
        m_id      = '0;
        m_last    = 39;
        rst       = 1'b1;
        req       = '0;
        grant_ack = 1'b0;
        all_ones  = '1;

        tbl[0]  = '{1'b1, 40'h0,            1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 40'h00_0000_0011, 1'b1, 1'b1, 6'd0};
        tbl[2]  = '{1'b0, 40'h00_0000_0011, 1'b1, 1'b1, 6'd4};
        tbl[3]  = '{1'b0, 40'h00_0000_0011, 1'b1, 1'b1, 6'd0};
        tbl[4]  = '{1'b0, 40'h00_0000_0011, 1'b1, 1'b1, 6'd4};
        tbl[5]  = '{1'b0, 40'h00_0000_0080, 1'b1, 1'b1, 6'd7};
        tbl[6]  = '{1'b0, 40'h00_0000_1000, 1'b0, 1'b1, 6'd7};
        tbl[7]  = '{1'b0, 40'h00_0000_1000, 1'b0, 1'b1, 6'd7};
        tbl[8]  = '{1'b0, 40'h00_0000_1000, 1'b0, 1'b1, 6'd7};
        tbl[9]  = '{1'b0, 40'h00_0000_1000, 1'b1, 1'b1, 6'd12};
        tbl[10] = '{1'b0, 40'h40_0000_0000, 1'b1, 1'b1, 6'd38};
        tbl[11] = '{1'b0, 40'h80_0000_0021, 1'b1, 1'b1, 6'd39};
        tbl[12] = '{1'b0, 40'h80_0000_0021, 1'b1, 1'b1, 6'd0};
        tbl[13] = '{1'b0, 40'h80_0000_0021, 1'b1, 1'b1, 6'd5};
        tbl[14] = '{1'b0, 40'h80_0000_0021, 1'b1, 1'b1, 6'd39};
        tbl[15] = '{1'b0, 40'h0,            1'b1, 1'b0, 6'd39};
        tbl[16] = '{1'b0, 40'h0,            1'b0, 1'b0, 6'd39};
        tbl[17] = '{1'b0, 40'h0,            1'b1, 1'b0, 6'd39};
        tbl[18] = '{1'b0, 40'hFF_FFFF_FFFF, 1'b1, 1'b1, 6'd0};
        tbl[19] = '{1'b0, 40'h00_0010_0000, 1'b1, 1'b1, 6'd20};
        tbl[20] = '{1'b1, 40'hFF_FFFF_FFFF, 1'b0, 1'b0, 6'd0};
        tbl[21] = '{1'b0, 40'hFF_FFFF_FFFF, 1'b0, 1'b1, 6'd0};

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].ack);
            check($sformatf("tbl%0d_valid", i), 64'(grant_valid), 64'(tbl[i].ev));
            check($sformatf("tbl%0d_id", i), 64'(grant_id), 64'(tbl[i].eid));
            check($sformatf("tbl%0d_onehot", i), 64'(grant_onehot),
                  64'(onehot_of(tbl[i].ev, tbl[i].eid)));
        end

        // Full sweep: every slot requesting, ack every cycle for two rotations.
        step(1'b1, '0, 1'b0);
        for (int i = 0; i < 40; i++) counts[i] = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, all_ones, 1'b1);
            check($sformatf("sweep%0d_valid", i), 64'(grant_valid), 64'd1);
            check($sformatf("sweep%0d_id", i), 64'(grant_id), 64'(i % 40));
            if (grant_id < 6'd40) counts[grant_id]++;
        end
        ok = 1'b1;
        for (int i = 0; i < 40; i++) if (counts[i] != 2) ok = 1'b0;
        check("sweep_each_twice", 64'(ok), 64'd1);

        // Randomized traffic against the model.
        step(1'b1, '0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic        rr;
            logic        aa;
            int unsigned mode;
            r    = {8'($urandom), $urandom};
            mode = $urandom_range(0, 5);
            case (mode)
                0: r = '0;
                1: r = r & {8'($urandom), $urandom} & {8'($urandom), $urandom};
                2: r = onehot_of(1'b1, 6'($urandom_range(0, 39)));
                3: r = r | {8'($urandom), $urandom};
                default: ;
            endcase
            rr = ($urandom_range(0, 199) == 0);
            aa = ($urandom_range(0, 3) != 0);
            step(rr, r, aa);
            check("rand_valid", 64'(grant_valid), 64'(m_valid));
            if (m_valid) check("rand_id", 64'(grant_id), 64'(m_id));
            check("rand_onehot", 64'(grant_onehot), 64'(onehot_of(m_valid, m_id)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
